bus_c_write_bank: RTL
=====================

Name: bus_c_write_bank

Overview:
- Receiving end of the datapath bus: takes the 16-bit result bus (BUS_C, driven by the ALU) and writes it into the selected destination register.
- Destination codes use the same encoding as the bus-B source select, so any code names the same register on both buses.
- Holds the architectural registers (PC, R1, R2, TR, R, AC, AR, IR) that feed the bus-B source mux.
- Runs the byte-wide write handshake to data RAM.

Parameters:
- DATA_WIDTH, 16, width of bus and of all 16-bit registers.
- RAM_WIDTH, 8, width of RAM data and of IR; must be <= DATA_WIDTH.

Ports:
- CLOCK  input  1  single system clock; all state changes on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- WRITE_EN  input  1  qualifies WRITE_SELECT this cycle.
- WRITE_SELECT  input  4  destination code: 0 RAM, 1 PC, 2 R1, 3 R2, 4 TR, 5 R, 6 AC, 7 IR, 8 AR, 9-15 no destination.
- BUS_C  input  DATA_WIDTH  value to be written.
- INC_PC  input  1  increment PC.
- INC_AR  input  1  increment AR.
- INC_R1  input  1  increment R1.
- CLEAR_AC  input  1  clear AC.
- RAM_ACK  input  1  RAM accepted the pending write.
- PC, R1, R2, TR, R, AC, AR  output  DATA_WIDTH each  register contents (registered outputs).
- IR  output  RAM_WIDTH  instruction register.
- Z_FLAG  output  1  set when the last AC update gave zero.
- DATA_TO_RAM  output  RAM_WIDTH  byte being written.
- RAM_WE  output  1  write request to RAM.
- RAM_BUSY  output  1  RAM write handshake in progress (equals RAM_WE).

Behaviour:
- Reset:
  - On a clock edge with RESET=1, every register, IR, DATA_TO_RAM, Z_FLAG, RAM_WE and RAM_BUSY go to 0, and the FSM goes to IDLE.
  - RESET overrides all other inputs.
  - Reset during WAIT_ACK abandons the write; a late RAM_ACK after reset is ignored.
- Register write:
  - WRITE_EN=1 with code 1-6 or 8 loads BUS_C into that register at the next edge (1-cycle latency).
  - Code 7 loads BUS_C[RAM_WIDTH-1:0] into IR.
  - Codes 9-15, or WRITE_EN=0, write nothing.
- Increments:
  - INC_PC, INC_AR and INC_R1 each add 1 modulo 2^DATA_WIDTH, so 16'hFFFF wraps to 16'h0000.
  - Increments are independent; all three may occur in the same cycle.
- Priority on one register in the same cycle: bus write wins over increment or clear.
  - Example: WRITE_SELECT=1 with INC_PC=1 gives PC=BUS_C, not BUS_C+1.
  - CLEAR_AC with a bus write to AC gives AC=BUS_C.
- Z_FLAG:
  - Updated only when AC is updated: Z_FLAG = (new AC value == 0).
  - CLEAR_AC sets Z_FLAG=1.
  - Otherwise Z_FLAG holds.
- RAM write FSM, states IDLE and WAIT_ACK:
  - IDLE: WRITE_EN=1 with code 0 latches BUS_C[RAM_WIDTH-1:0] into DATA_TO_RAM, sets RAM_WE=1 and moves to WAIT_ACK on that edge.
  - WAIT_ACK: RAM_WE and DATA_TO_RAM hold steady. RAM_ACK=1 sampled at an edge gives RAM_WE=0 and IDLE after that edge.
  - A code-0 request during WAIT_ACK, including the acking cycle, is dropped. DATA_TO_RAM is unchanged and no error is flagged; the controller must check RAM_BUSY first.
  - Register writes and increments proceed normally while WAIT_ACK is active.
  - RAM_ACK in IDLE is ignored.
  - The minimum write occupies RAM_WE for 1 cycle when RAM_ACK is held high.
- No combinational path from any input to any output.

Test Plan:
- Reset, then WRITE_EN=1, WRITE_SELECT=2, BUS_C=16'h0880 -> R1=16'h0880 after 1 edge; all other registers stay 0.
- PC=16'hFFFF, INC_PC=1 for one cycle -> PC=16'h0000. Then WRITE_SELECT=1, BUS_C=16'h1080, INC_PC=1 together -> PC=16'h1080.
- WRITE_SELECT=7, BUS_C=16'hAB77 -> IR=8'h77. WRITE_SELECT=9..15 with BUS_C=16'h1234 -> no register changes.
- AC write of 16'h0000 -> Z_FLAG=1. AC write of 16'h00C0 -> Z_FLAG=0. CLEAR_AC -> AC=0, Z_FLAG=1.
- WRITE_SELECT=0, BUS_C=16'h1255 with RAM_ACK=0 for 3 cycles:
  - DATA_TO_RAM=8'h55 and RAM_WE=1 held for all 3 cycles.
  - A second code-0 write of 16'h00AA in that window is dropped.
  - RAM_ACK=1 -> RAM_WE=0 the next cycle.
- Assert RESET while in WAIT_ACK -> RAM_WE=0 and DATA_TO_RAM=0 next edge; a following RAM_ACK pulse causes no change.

Source files
------------

// File: rtl/bus_c_write_bank.sv
// Write side of the datapath: BUS_C lands in the selected architectural register,
// and code 0 starts a byte-wide write to data RAM through a two-state handshake.
module bus_c_write_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int RAM_WIDTH  = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  WRITE_EN,
    input  logic [3:0]            WRITE_SELECT,
    input  logic [DATA_WIDTH-1:0] BUS_C,
    input  logic                  INC_PC,
    input  logic                  INC_AR,
    input  logic                  INC_R1,
    input  logic                  CLEAR_AC,
    input  logic                  RAM_ACK,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] R1,
    output logic [DATA_WIDTH-1:0] R2,
    output logic [DATA_WIDTH-1:0] TR,
    output logic [DATA_WIDTH-1:0] R,
    output logic [DATA_WIDTH-1:0] AC,
    output logic [DATA_WIDTH-1:0] AR,
    output logic [RAM_WIDTH-1:0]  IR,
    output logic                  Z_FLAG,
    output logic [RAM_WIDTH-1:0]  DATA_TO_RAM,
    output logic                  RAM_WE,
    output logic                  RAM_BUSY
);

    localparam logic [3:0] SEL_RAM = 4'd0;
    localparam logic [3:0] SEL_PC  = 4'd1;
    localparam logic [3:0] SEL_R1  = 4'd2;
    localparam logic [3:0] SEL_R2  = 4'd3;
    localparam logic [3:0] SEL_TR  = 4'd4;
    localparam logic [3:0] SEL_R   = 4'd5;
    localparam logic [3:0] SEL_AC  = 4'd6;
    localparam logic [3:0] SEL_IR  = 4'd7;
    localparam logic [3:0] SEL_AR  = 4'd8;

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } ram_state_t;

    ram_state_t state, state_next;

    logic wr_ram, wr_pc, wr_r1, wr_r2, wr_tr, wr_r, wr_ac, wr_ir, wr_ar;

    always_comb begin
        wr_ram = WRITE_EN && (WRITE_SELECT == SEL_RAM);
        wr_pc  = WRITE_EN && (WRITE_SELECT == SEL_PC);
        wr_r1  = WRITE_EN && (WRITE_SELECT == SEL_R1);
        wr_r2  = WRITE_EN && (WRITE_SELECT == SEL_R2);
        wr_tr  = WRITE_EN && (WRITE_SELECT == SEL_TR);
        wr_r   = WRITE_EN && (WRITE_SELECT == SEL_R);
        wr_ac  = WRITE_EN && (WRITE_SELECT == SEL_AC);
        wr_ir  = WRITE_EN && (WRITE_SELECT == SEL_IR);
        wr_ar  = WRITE_EN && (WRITE_SELECT == SEL_AR);
    end

    // A bus write to a register takes priority over its increment or clear.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            PC     <= '0;
            R1     <= '0;
            R2     <= '0;
            TR     <= '0;
            R      <= '0;
            AC     <= '0;
            AR     <= '0;
            IR     <= '0;
            Z_FLAG <= 1'b0;
        end else begin
            if (wr_pc)       PC <= BUS_C;
            else if (INC_PC) PC <= PC + ONE;

            if (wr_r1)       R1 <= BUS_C;
            else if (INC_R1) R1 <= R1 + ONE;

            if (wr_ar)       AR <= BUS_C;
            else if (INC_AR) AR <= AR + ONE;

            if (wr_r2) R2 <= BUS_C;
            if (wr_tr) TR <= BUS_C;
            if (wr_r)  R  <= BUS_C;
            if (wr_ir) IR <= BUS_C[RAM_WIDTH-1:0];

            if (wr_ac) begin
                AC     <= BUS_C;
                Z_FLAG <= (BUS_C == '0);
            end else if (CLEAR_AC) begin
                AC     <= '0;
                Z_FLAG <= 1'b1;
            end
        end
    end

    // RAM handshake: RAM_WE acts as valid and RAM_ACK as ready. Once RAM_WE rises,
    // it and DATA_TO_RAM stay fixed until an edge samples RAM_ACK=1; that edge
    // completes the transfer. Code-0 requests are taken only in IDLE.
    always_ff @(posedge CLOCK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (wr_ram)  state_next = WAIT_ACK;
            WAIT_ACK: if (RAM_ACK) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        RAM_WE   = (state == WAIT_ACK);
        RAM_BUSY = (state == WAIT_ACK);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            DATA_TO_RAM <= '0;
        end else if ((state == IDLE) && wr_ram) begin
            DATA_TO_RAM <= BUS_C[RAM_WIDTH-1:0];
        end
    end

endmodule
